// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide sequencer owning the HI/LO register pair
module muldiv_seq #(
   parameter  int width = 32,
   localparam int cnt_w = $clog2(width) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [width-1:0] src_a,
   input  logic [width-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] hi,
   output logic [width-1:0] lo
);

   localparam logic [2:0] OP_MULT = 3'd1;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   localparam logic [cnt_w-1:0] cnt_init = cnt_w'(width);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t               state;
   logic [cnt_w-1:0]     cnt;
   logic [2*width-1:0]   acc;
   logic [width-1:0]     opnd;
   logic                 is_div;
   logic                 neg_res;
   logic                 neg_rem;

   logic                 op_signed;
   logic                 a_neg;
   logic                 b_neg;
   logic [width-1:0]     a_mag;
   logic [width-1:0]     b_mag;

   logic [width:0]       mul_sum;
   logic [2*width-1:0]   mul_next;
   logic [width:0]       div_trial;
   logic [2*width-1:0]   div_next;

   logic [2*width-1:0]   prod_fix;
   logic [width-1:0]     quo_fix;
   logic [width-1:0]     rem_fix;
   logic [2*width-1:0]   result;

   always_comb begin
      op_signed = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = op_signed & src_a[width-1];
      b_neg     = op_signed & src_b[width-1];
      a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
      b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
   end

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   always_comb begin
      mul_sum  = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, opnd} : {(width+1){1'b0}});
      mul_next = {mul_sum, acc[width-1:1]};
   end

   // Divide: acc = {remainder, dividend/quotient}; a clear top bit of the trial means no borrow.
   always_comb begin
      div_trial = {acc[2*width-1:width], acc[width-1]} - {1'b0, opnd};
      if (!div_trial[width])
         div_next = {div_trial[width-1:0], acc[width-2:0], 1'b1};
      else
         div_next = {acc[2*width-2:0], 1'b0};
   end

   // Divide-by-zero and MIN/-1 fall out of the same magnitude loop plus sign fix.
   always_comb begin
      prod_fix = neg_res ? (~acc + 1'b1) : acc;
      quo_fix  = neg_res ? (~acc[width-1:0] + 1'b1) : acc[width-1:0];
      rem_fix  = neg_rem ? (~acc[2*width-1:width] + 1'b1) : acc[2*width-1:width];
      result   = is_div ? {rem_fix, quo_fix} : prod_fix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (!op[2]) begin
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        opnd    <= op[1] ? b_mag : a_mag;
                        acc     <= {{width{1'b0}}, (op[1] ? a_mag : b_mag)};
                        cnt     <= cnt_init;
                        busy    <= 1'b1;
                        state   <= CALC;
                     end else if (op == OP_MTHI) begin
                        hi <= src_a;
                     end else if (op == OP_MTLO) begin
                        lo <= src_a;
                     end
                  end
               end
               CALC: begin
                  acc <= is_div ? div_next : mul_next;
                  cnt <= cnt - 1'b1;
                  if (cnt == cnt_last)
                     state <= FIX;
               end
               FIX: begin
                  hi    <= result[2*width-1:width];
                  lo    <= result[width-1:0];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp;
   int n_fail;

   muldiv_seq #(.width(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; holds start for one cycle and returns at the first busy sample.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_result(output int lat, output int bcnt, output bit ok);
      lat  = 0;
      bcnt = 0;
      ok   = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            ok  = 1'b1;
            lat = i + 1;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'd0;
      src_a = '0;
      src_b = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_busy_done got %b expected 00", {busy, done});
      end
      n_cmp++;
      if ({hi, lo} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_hilo got %h expected %h", {hi, lo}, 64'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_multu;
      int lat, bcnt;
      bit ok;
      issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL multu_timeout got no done expected done within 200 cycles");
      end
      n_cmp++;
      if (lat != 34) begin
         n_fail++;
         $display("FAIL multu_latency got %0d expected 34", lat);
      end
      n_cmp++;
      if (bcnt != 33) begin
         n_fail++;
         $display("FAIL multu_busy_cycles got %0d expected 33", bcnt);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL multu_busy_at_done got %b expected 0", busy);
      end
      n_cmp++;
      if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
         n_fail++;
         $display("FAIL multu_result got %h expected %h", {hi, lo}, 64'hFFFFFFFE_00000001);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL multu_done_pulse got %b expected 0", done);
      end
   endtask

   task automatic test_mult;
      int lat, bcnt;
      bit ok;
      issue(3'd1, 32'hFFFFFFF9, 32'd3);
      n_cmp++;
      if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
         n_fail++;
         $display("FAIL mult_hold_during_calc got %h expected %h", {hi, lo}, 64'hFFFFFFFE_00000001);
      end
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || {hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
         n_fail++;
         $display("FAIL mult_result got %h ok=%0d expected %h", {hi, lo}, ok, 64'hFFFFFFFF_FFFFFFEB);
      end
      @(negedge clk);
   endtask

   task automatic test_div;
      int lat, bcnt;
      bit ok;
      issue(3'd3, 32'hFFFFFFF9, 32'd2);
      src_a = 32'h55555555;
      src_b = 32'h0;
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || lo !== 32'hFFFFFFFD) begin
         n_fail++;
         $display("FAIL div_quotient got %h ok=%0d expected %h", lo, ok, 32'hFFFFFFFD);
      end
      n_cmp++;
      if (hi !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL div_remainder got %h expected %h", hi, 32'hFFFFFFFF);
      end
      issue(3'd2, 32'd50, 32'd7);
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || {hi, lo} !== {32'd1, 32'd7}) begin
         n_fail++;
         $display("FAIL divu_50_7 got %h ok=%0d expected %h", {hi, lo}, ok, {32'd1, 32'd7});
      end
      @(negedge clk);
   endtask

   task automatic test_div_zero;
      int lat, bcnt;
      bit ok;
      issue(3'd2, 32'd100, 32'd0);
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || {hi, lo} !== {32'd100, 32'hFFFFFFFF}) begin
         n_fail++;
         $display("FAIL divu_by_zero got %h ok=%0d expected %h", {hi, lo}, ok, {32'd100, 32'hFFFFFFFF});
      end
      issue(3'd3, 32'hFFFFFFFB, 32'd0);
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || {hi, lo} !== {32'hFFFFFFFB, 32'd1}) begin
         n_fail++;
         $display("FAIL div_neg_by_zero got %h ok=%0d expected %h", {hi, lo}, ok, {32'hFFFFFFFB, 32'd1});
      end
      issue(3'd3, 32'd9, 32'd0);
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || {hi, lo} !== {32'd9, 32'hFFFFFFFF}) begin
         n_fail++;
         $display("FAIL div_pos_by_zero got %h ok=%0d expected %h", {hi, lo}, ok, {32'd9, 32'hFFFFFFFF});
      end
      @(negedge clk);
   endtask

   task automatic test_overflow;
      int lat, bcnt;
      bit ok;
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || {hi, lo} !== {32'h0, 32'h80000000}) begin
         n_fail++;
         $display("FAIL div_overflow got %h ok=%0d expected %h", {hi, lo}, ok, {32'h0, 32'h80000000});
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int lat, bcnt;
      bit ok;
      issue(3'd0, 32'd3, 32'd5);
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || {hi, lo} !== 64'd15) begin
         n_fail++;
         $display("FAIL b2b_first got %h ok=%0d expected %h", {hi, lo}, ok, 64'd15);
      end
      issue(3'd2, 32'd50, 32'd7);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept_on_done got busy=%b expected 1", busy);
      end
      wait_result(lat, bcnt, ok);
      n_cmp++;
      if (!ok || lat != 34 || {hi, lo} !== {32'd1, 32'd7}) begin
         n_fail++;
         $display("FAIL b2b_second got %h lat=%0d expected %h lat=34", {hi, lo}, lat, {32'd1, 32'd7});
      end
      @(negedge clk);
   endtask

   task automatic test_mthi_mtlo;
      start = 1'b1;
      op    = 3'd4;
      src_a = 32'h12345678;
      @(negedge clk);
      op    = 3'd5;
      src_a = 32'h9ABCDEF0;
      n_cmp++;
      if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL mthi got hi=%h busy=%b done=%b expected hi=12345678 busy=0 done=0", hi, busy, done);
      end
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({hi, lo} !== 64'h12345678_9ABCDEF0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL mtlo got %h busy=%b done=%b expected %h busy=0 done=0", {hi, lo}, busy, done, 64'h12345678_9ABCDEF0);
      end
      op    = 3'd6;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({hi, lo} !== 64'h12345678_9ABCDEF0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reserved_op got %h busy=%b expected %h busy=0", {hi, lo}, busy, 64'h12345678_9ABCDEF0);
      end
   endtask

   task automatic test_flush;
      bit saw_done;
      issue(3'd2, 32'd50, 32'd7);
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h12345678_9ABCDEF0) begin
         n_fail++;
         $display("FAIL flush_calc got busy=%b done=%b hilo=%h expected 0 0 %h", busy, done, {hi, lo}, 64'h12345678_9ABCDEF0);
      end
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL flush_no_done got done seen expected none");
      end
      start = 1'b1;
      flush = 1'b1;
      op    = 3'd2;
      src_a = 32'd50;
      src_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      saw_done = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_with_start got busy=%b expected 0", busy);
      end
      repeat (40) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done || {hi, lo} !== 64'h12345678_9ABCDEF0) begin
         n_fail++;
         $display("FAIL flush_with_start_quiet got activity=%0d hilo=%h expected 0 %h", saw_done, {hi, lo}, 64'h12345678_9ABCDEF0);
      end
      issue(3'd0, 32'd6, 32'd7);
      repeat (32) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL fix_cycle_busy got busy=%b done=%b expected 1 0", busy, done);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'h12345678_9ABCDEF0) begin
         n_fail++;
         $display("FAIL flush_fix got done=%b busy=%b hilo=%h expected 0 0 %h", done, busy, {hi, lo}, 64'h12345678_9ABCDEF0);
      end
   endtask

   task automatic test_busy_ignore_reset;
      issue(3'd0, 32'h0000FFFF, 32'h0000FFFF);
      start = 1'b1;
      op    = 3'd5;
      src_a = 32'hDEADBEEF;
      repeat (2) @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || lo !== 32'h9ABCDEF0) begin
         n_fail++;
         $display("FAIL mtlo_while_busy got busy=%b lo=%h expected 1 %h", busy, lo, 32'h9ABCDEF0);
      end
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0) begin
         n_fail++;
         $display("FAIL async_reset got busy=%b done=%b hilo=%h expected 0 0 0", busy, done, {hi, lo});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0) begin
         n_fail++;
         $display("FAIL after_reset_idle got busy=%b done=%b hilo=%h expected 0 0 0", busy, done, {hi, lo});
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_zero();
      test_overflow();
      test_back_to_back();
      test_mthi_mtlo();
      test_flush();
      test_busy_ignore_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the CPU core.
- Takes MULT/MULTU/DIV/DIVU and MTHI/MTLO requests from the execute stage.
- Runs a radix-2 shift-add or restoring-divide loop over `width` cycles, with a busy/done handshake so the pipeline can stall.
- Replaces the single-cycle wide multiplier/divider path in the ALU for timing closure.

Parameters:
- width, 32, operand width and HI/LO register width (even, >= 4)
- cnt_w, $clog2(width)+1, iteration counter width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled only while busy=0
- op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6/7 reserved
- src_a  input  width  multiplicand / dividend / MTHI-MTLO data
- src_b  input  width  multiplier / divisor
- flush  input  1  pipeline flush; cancels any in-flight operation
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse in the cycle HI/LO take the new result
- hi  output  width  HI register (product upper half / remainder)
- lo  output  width  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and internal operands cleared. Reset mid-operation aborts immediately with no HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op 0-3 and flush=0: latch magnitudes of src_a/src_b (signed ops take |x|; unsigned ops use raw values), latch sign info, counter=width; next=CALC.
  - start=1 with op 4/5 and flush=0: hi (or lo) <= src_a at this edge; stay IDLE; done=0, busy=0.
  - op 6/7: ignored.
- CALC:
  - busy=1. One iteration per cycle, counter decrements; after `width` iterations go to FIX.
  - Multiply: 2*width-bit accumulator, shift-add.
  - Divide: restoring, 1 quotient bit per cycle.
- FIX (1 cycle):
  - busy=1. Apply sign correction.
  - MULT: negate the 2*width product if sign(a)^sign(b).
  - DIV: negate quotient if sign(a)^sign(b); remainder takes sign of a.
  - At the FIX->IDLE edge: {hi,lo} <= result, done=1 for that following cycle, busy=0.
- Latency: start accepted at edge N; done=1 and hi/lo valid during cycle N+width+2 (CALC is width cycles, FIX is 1). The next start is accepted in the same cycle done=1.
- busy is registered: high from the cycle after start is accepted through the FIX cycle inclusive.
- start while busy=1: ignored, including MTHI/MTLO; no queueing.
- flush=1 in any state: next state IDLE; hi/lo unchanged; done stays 0.
- flush and start in the same cycle: flush wins and start is dropped.
- flush in the FIX cycle: the result is discarded.
- Divide by zero (defined, no trap):
  - DIVU: lo=all ones, hi=src_a.
  - DIV: lo=1 if a<0 else all ones; hi=src_a.
- Signed overflow: DIV of the most-negative value by -1 gives lo=the most-negative value (0x80000000 at width 32), hi=0.
- Operands are captured at acceptance; src_a/src_b may change freely while busy.
- hi/lo are held stable during CALC/FIX; readers see the old values until done.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=-7 (0xFFFFFFF9) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI src_a=0x12345678 then MTLO src_a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each, busy never asserted, done=0.
- Start DIVU 50/7, assert flush at cycle 10 -> state IDLE next cycle, busy=0, hi/lo hold prior values, no done. Repeat with start+flush in the same cycle -> nothing accepted.
- Start MULTU, drive start with MTLO while busy, then pull rst_n low mid-CALC -> MTLO ignored; on reset, busy=done=hi=lo=0 asynchronously (before the next clock edge).
